flash_programmer: RTL and testbench
===================================

FLASH_PROGRAMMER -- requirements
Module: flash_programmer

Interface
REQ-001 SHALL have parameter WE_CYCLES, default 4: flash_we_n low time in clk cycles (legal range 1..15).
REQ-002 SHALL have parameter RD_CYCLES, default 6: flash_oe_n low time before the status sample (legal range 1..15).
REQ-003 SHALL have parameter POLL_LIMIT, default 65535: maximum status reads before timeout.
REQ-004 SHALL have port clk, input, 1: the only clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port bus_addr, input, Flash_addr_t: halfword-aligned target address (bit 0 ignored).
REQ-007 SHALL have port bus_data_write, input, Word_t: 32-bit data; the low halfword goes to bus_addr, the high halfword to bus_addr+2.
REQ-008 SHALL have port write_op, input, 1: program request.
REQ-009 SHALL have port erase_op, input, 1: block-erase request for the block containing bus_addr.
REQ-010 SHALL have port busy, output, 1: operation in progress.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port error, output, 1: the last operation failed; valid while done=1, held until the next accept.
REQ-013 SHALL have port flash_a, output, Flash_addr_t: flash address.
REQ-014 SHALL have ports flash_d_o (output, 16), flash_d_i (input, 16) and flash_d_oe (output, 1): split data bus; the tri-state buffer sits at top level.
REQ-015 SHALL have ports flash_ce_n, flash_oe_n and flash_we_n, output, 1 each: active-low flash strobes.

Function
REQ-016 SHALL accept a request only in IDLE, on a rising clk edge where write_op or erase_op is 1.
- bus_addr and bus_data_write are latched at that edge.
- busy rises in the same cycle the request is accepted.
REQ-017 SHALL give write_op priority when write_op and erase_op are both 1; erase_op is then dropped, not queued.
REQ-018 SHALL ignore write_op and erase_op while busy=1.
REQ-019 SHALL run every bus write cycle as follows.
- 1 setup cycle: ce_n=0, address/data driven, d_oe=1, we_n=1.
- WE_CYCLES cycles with we_n=0.
- 1 hold cycle with we_n=1.
- Then ce_n=1, d_oe=0.
REQ-020 SHALL run every status read cycle as ce_n=0, oe_n=0, d_oe=0 for RD_CYCLES cycles, sampling flash_d_i on the last of them, then ce_n=oe_n=1 for one cycle.
REQ-021 SHALL sequence a program operation through these states: CLR (write 0x0050) -> PGM_CMD (write 0x0040 at addr) -> PGM_DATA (write the halfword at addr) -> POLL -> PGM_CMD for the second halfword (addr+2) -> ... -> RESTORE -> DONE.
REQ-022 SHALL sequence an erase operation as CLR -> ERS_CMD (write 0x0020) -> ERS_CONF (write 0x00D0 at addr) -> POLL -> RESTORE -> DONE.
REQ-023 SHALL, in POLL, repeat status reads until SR bit 7 = 1.
- SR bits 5, 4, 3 or 1 set -> error=1; remaining halfword skipped; go to RESTORE.
REQ-024 SHALL count status reads with a 16-bit poll counter, cleared on each POLL entry.
- Reaching POLL_LIMIT -> error=1, go to RESTORE.
REQ-025 SHALL issue RESTORE as a write of 0x00FF at addr, returning the flash to read-array mode.
REQ-026 SHALL assert done=1 for exactly one cycle in DONE, with busy=0 in that same cycle; the next state is IDLE.
REQ-027 SHALL make the program operation's done occur no earlier than 4*(WE_CYCLES+2) + 2*(RD_CYCLES+1) cycles after accept.
REQ-028 SHALL compute addr+2 modulo 2^width(Flash_addr_t), wrapping without any flag.
REQ-029 SHALL never assert oe_n=0 and we_n=0 in the same cycle.
REQ-030 SHALL never assert d_oe=1 while oe_n=0.

Reset
REQ-031 SHALL, while rst=0, immediately hold state=IDLE, busy=0, done=0, error=0, flash_ce_n=1, flash_oe_n=1, flash_we_n=1, flash_d_oe=0, flash_a=0, flash_d_o=0.
REQ-032 SHALL abort any operation on reset mid-operation, with no RESTORE issued and no done pulse.

Structure
REQ-033 SHALL take Flash_addr_t, Word_t and Bit_t from the shared defines header.
REQ-034 SHALL place the flash command constants (0x50, 0x40, 0x20, 0xD0, 0xFF, 0x70) and the SR bit positions in that shared header.
REQ-035 SHALL implement the bus-cycle timer (WE/RD strobe generation plus a cycle_done strobe) as one sub-module, flash_bus_cycle, driven by the top-level FSM.

Verification
REQ-036 SHALL cover a plain program: write_op, addr=0x000100, data=0xDEADBEEF, model SR=0x80 after 3 polls.
- Required: the flash model sees writes 0x50, 0x40, 0xBEEF@0x100, 0x40, 0xDEAD@0x102, 0xFF.
- Required: one done pulse, error=0.
REQ-037 SHALL cover an erase: erase_op, addr=0x020000.
- Required: writes 0x50, 0x20, 0xD0@0x020000, polls until SR=0x80, then 0xFF.
- Required: done=1, error=0.
REQ-038 SHALL cover a program error: the model returns SR=0x90 on the first halfword.
- Required: no second-halfword writes, 0xFF issued, done with error=1.
REQ-039 SHALL cover a timeout: POLL_LIMIT=8, model SR fixed at 0x00.
- Required: exactly 8 status reads, then RESTORE, done with error=1.
REQ-040 SHALL cover arbitration and busy-ignore.
- write_op and erase_op both high: only program executed.
- write_op pulsed while busy: ignored, exactly one done.
REQ-041 SHALL cover reset mid-operation: rst=0 during PGM_DATA.
- Required: all strobes high and busy=0 within the same cycle, no done pulse.
- Required: a new write_op after reset completes normally.
REQ-042 SHALL cover address wrap: addr = maximum halfword address.
- Required: the second halfword is written at address 0x000000.

Source files
------------

// File: rtl/flash_programmer_pkg.sv
// Shared types, flash command set and status-register layout for the flash programmer.
package flash_programmer_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned POLL_W = 16;

  typedef logic [ADDR_W-1:0] Flash_addr_t;
  typedef logic [WORD_W-1:0] Word_t;
  typedef logic [HALF_W-1:0] Half_t;
  typedef logic              Bit_t;

  localparam Flash_addr_t ADDR_ALIGN = ~ADDR_W'(1);

  localparam Half_t CMD_CLR_SR     = 16'h0050;
  localparam Half_t CMD_PROGRAM    = 16'h0040;
  localparam Half_t CMD_ERASE      = 16'h0020;
  localparam Half_t CMD_CONFIRM    = 16'h00D0;
  localparam Half_t CMD_READ_ARRAY = 16'h00FF;
  localparam Half_t CMD_READ_SR    = 16'h0070;

  localparam int unsigned SR_READY     = 7;
  localparam int unsigned SR_ERASE_ERR = 5;
  localparam int unsigned SR_PGM_ERR   = 4;
  localparam int unsigned SR_VPP_ERR   = 3;
  localparam int unsigned SR_LOCK_ERR  = 1;

  typedef enum logic [2:0] {
    B_IDLE, B_SETUP, B_WE, B_HOLD, B_RD, B_RECOV
  } bus_state_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_PGM_CMD, S_PGM_DATA, S_ERS_CMD, S_ERS_CONF,
    S_POLL, S_RESTORE, S_DONE
  } prog_state_e;

  // One flash bus transaction as handed from the sequencer to the cycle timer
  typedef struct packed {
    Flash_addr_t addr;
    Half_t       data;
    logic        is_read;
  } bus_req_t;

  function automatic bus_req_t mk_req(input Flash_addr_t addr, input Half_t data,
                                      input logic is_read);
    bus_req_t r;
    r.addr    = addr;
    r.data    = data;
    r.is_read = is_read;
    return r;
  endfunction

  function automatic logic sr_failed(input Half_t sr);
    return sr[SR_ERASE_ERR] | sr[SR_PGM_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Flash bus cycle timer: generates CE/WE/OE/data-enable strobes for one write or
// status read and pulses cycle_done_o once the bus is released.
module flash_bus_cycle
  import flash_programmer_pkg::*;
#(
  parameter int unsigned WE_CYCLES = 4,
  parameter int unsigned RD_CYCLES = 6
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start_i,
  input  logic  is_read_i,
  input  Half_t d_i,
  output logic  ce_n_o,
  output logic  oe_n_o,
  output logic  we_n_o,
  output logic  d_oe_o,
  output logic  cycle_done_o,
  output Half_t status_o
);

  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             d_oe_q, d_oe_d;
  logic             done_q, done_d;
  Half_t            status_q, status_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= B_IDLE;
      cnt_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      d_oe_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      d_oe_q   <= d_oe_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  // Strobes are decoded from the next state so each register matches its phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    done_d   = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (start_i) begin
          state_d = is_read_i ? B_RD : B_SETUP;
          cnt_d   = '0;
        end
      end
      B_SETUP: begin
        state_d = B_WE;
        cnt_d   = '0;
      end
      B_WE: begin
        if (cnt_q == WE_LAST) state_d = B_HOLD;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      B_HOLD: begin
        state_d = B_IDLE;
        done_d  = 1'b1;
      end
      B_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d  = B_RECOV;
          status_d = d_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_RECOV: begin
        state_d = B_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = B_IDLE;
    endcase
    ce_n_d = !(state_d inside {B_SETUP, B_WE, B_HOLD, B_RD});
    we_n_d = (state_d != B_WE);
    oe_n_d = (state_d != B_RD);
    d_oe_d = (state_d inside {B_SETUP, B_WE, B_HOLD});
  end

  assign ce_n_o       = ce_n_q;
  assign oe_n_o       = oe_n_q;
  assign we_n_o       = we_n_q;
  assign d_oe_o       = d_oe_q;
  assign cycle_done_o = done_q;
  assign status_o     = status_q;

endmodule

// File: rtl/flash_programmer.sv
// Intel-style x16 flash programmer: sequences 32-bit programs and block erases
// as command/data bus cycles with status polling, timeout and read-array restore.
module flash_programmer
  import flash_programmer_pkg::*;
#(
  parameter int unsigned WE_CYCLES  = 4,
  parameter int unsigned RD_CYCLES  = 6,
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  Flash_addr_t bus_addr,
  input  Word_t       bus_data_write,
  input  Bit_t        write_op,
  input  Bit_t        erase_op,
  output Bit_t        busy,
  output Bit_t        done,
  output Bit_t        error,
  output Flash_addr_t flash_a,
  output logic [15:0] flash_d_o,
  input  logic [15:0] flash_d_i,
  output logic        flash_d_oe,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n
);

  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);

  prog_state_e       state_q, state_d;
  Flash_addr_t       addr_q, addr_d;
  Word_t             data_q, data_d;
  logic              erase_q, erase_d;
  logic              half_q, half_d;
  logic              err_q, err_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  bus_req_t          req_q, req_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bus_done;
  Half_t             bus_status;
  Flash_addr_t       cur_addr_c;
  Half_t             cur_half_c;
  logic [POLL_W-1:0] poll_next_c;

  flash_bus_cycle #(
    .WE_CYCLES(WE_CYCLES),
    .RD_CYCLES(RD_CYCLES)
  ) u_bus (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_q),
    .is_read_i   (req_q.is_read),
    .d_i         (flash_d_i),
    .ce_n_o      (flash_ce_n),
    .oe_n_o      (flash_oe_n),
    .we_n_o      (flash_we_n),
    .d_oe_o      (flash_d_oe),
    .cycle_done_o(bus_done),
    .status_o    (bus_status)
  );

  // Second halfword lives at addr+2, wrapping silently at the top of the array
  assign cur_addr_c  = half_q ? addr_q + ADDR_W'(2) : addr_q;
  assign cur_half_c  = half_q ? data_q[31:16] : data_q[15:0];
  assign poll_next_c = poll_q + POLL_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      erase_q <= 1'b0;
      half_q  <= 1'b0;
      err_q   <= 1'b0;
      poll_q  <= '0;
      req_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      erase_q <= erase_d;
      half_q  <= half_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      req_q   <= req_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Sequencer: each bus-owning state launches its cycle on entry and advances on bus_done
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    erase_d = erase_q;
    half_d  = half_q;
    err_d   = err_q;
    poll_d  = poll_q;
    req_d   = req_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_op || erase_op) begin
          addr_d  = bus_addr & ADDR_ALIGN;
          data_d  = bus_data_write;
          erase_d = ~write_op;
          half_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_CLR;
          start_d = 1'b1;
          req_d   = mk_req(bus_addr & ADDR_ALIGN, CMD_CLR_SR, 1'b0);
        end
      end
      S_CLR: begin
        if (bus_done) begin
          start_d = 1'b1;
          if (erase_q) begin
            state_d = S_ERS_CMD;
            req_d   = mk_req(addr_q, CMD_ERASE, 1'b0);
          end else begin
            state_d = S_PGM_CMD;
            req_d   = mk_req(cur_addr_c, CMD_PROGRAM, 1'b0);
          end
        end
      end
      S_PGM_CMD: begin
        if (bus_done) begin
          state_d = S_PGM_DATA;
          start_d = 1'b1;
          req_d   = mk_req(cur_addr_c, cur_half_c, 1'b0);
        end
      end
      S_ERS_CMD: begin
        if (bus_done) begin
          state_d = S_ERS_CONF;
          start_d = 1'b1;
          req_d   = mk_req(addr_q, CMD_CONFIRM, 1'b0);
        end
      end
      S_PGM_DATA, S_ERS_CONF: begin
        if (bus_done) begin
          state_d = S_POLL;
          start_d = 1'b1;
          poll_d  = '0;
          req_d   = mk_req(cur_addr_c, req_q.data, 1'b1);
        end
      end
      S_POLL: begin
        if (bus_done) begin
          poll_d  = poll_next_c;
          start_d = 1'b1;
          if (bus_status[SR_READY]) begin
            if (sr_failed(bus_status)) begin
              err_d   = 1'b1;
              state_d = S_RESTORE;
              req_d   = mk_req(addr_q, CMD_READ_ARRAY, 1'b0);
            end else if (!erase_q && !half_q) begin
              half_d  = 1'b1;
              state_d = S_PGM_CMD;
              req_d   = mk_req(addr_q + ADDR_W'(2), CMD_PROGRAM, 1'b0);
            end else begin
              state_d = S_RESTORE;
              req_d   = mk_req(addr_q, CMD_READ_ARRAY, 1'b0);
            end
          end else if (poll_next_c >= POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_RESTORE;
            req_d   = mk_req(addr_q, CMD_READ_ARRAY, 1'b0);
          end else begin
            req_d = mk_req(cur_addr_c, req_q.data, 1'b1);
          end
        end
      end
      S_RESTORE: begin
        if (bus_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign flash_a   = req_q.addr;
  assign flash_d_o = req_q.data;

endmodule

// File: tb/tb_flash_programmer.sv
// Bench for flash_programmer: behavioural x16 flash model plus an operation-level
// reference that predicts the write log, status-read count and error flag.
module tb_flash_programmer;
  import flash_programmer_pkg::*;

  localparam int unsigned WE = 4;
  localparam int unsigned RD = 6;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned LAT_MIN = 4 * (WE + 2) + 2 * (RD + 1);

  logic        clk = 1'b0;
  logic        rst;
  Flash_addr_t bus_addr;
  Word_t       bus_data_write;
  logic        write_op, erase_op;
  logic        busy, done, error;
  Flash_addr_t flash_a;
  logic [15:0] flash_d_o, flash_d_i;
  logic        flash_d_oe, flash_ce_n, flash_oe_n, flash_we_n;

  flash_programmer #(.WE_CYCLES(WE), .RD_CYCLES(RD), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data_write(bus_data_write),
    .write_op(write_op), .erase_op(erase_op), .busy(busy), .done(done), .error(error),
    .flash_a(flash_a), .flash_d_o(flash_d_o), .flash_d_i(flash_d_i),
    .flash_d_oe(flash_d_oe), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n)
  );

  always #5 clk = ~clk;

  // Flash model configuration (stimulus side) and state (monitor side)
  int          busy_reads = 0;
  logic [15:0] sr1 = 16'h0080, sr2 = 16'h0080;
  int          phase = 0, reads_since = 0, rd_total = 0, done_cnt = 0, proto_bad = 0;
  logic        expect_data = 1'b0, err_at_done = 1'b0, we_prev = 1'b1, oe_prev = 1'b1;
  logic [39:0] wr_log[$];

  assign flash_d_i = (reads_since >= busy_reads) ? ((phase <= 1) ? sr1 : sr2) : 16'h0000;

  always @(negedge clk) begin
    if (!rst) begin
      expect_data <= 1'b0;
      phase       <= 0;
      reads_since <= 0;
      we_prev     <= 1'b1;
      oe_prev     <= 1'b1;
    end else begin
      if ((!flash_oe_n && !flash_we_n) || (flash_d_oe && !flash_oe_n) || (done && busy) ||
          (!we_prev && flash_we_n && (flash_ce_n || !flash_d_oe)))
        proto_bad <= proto_bad + 1;
      if (done) begin
        done_cnt    <= done_cnt + 1;
        err_at_done <= error;
      end
      if (!we_prev && flash_we_n) begin
        wr_log.push_back({flash_a, flash_d_o});
        reads_since <= 0;
        if (expect_data) begin
          expect_data <= 1'b0;
          phase       <= phase + 1;
        end else if (flash_d_o == 16'h0040) expect_data <= 1'b1;
        else if (flash_d_o == 16'h00D0)    phase <= phase + 1;
        else if (flash_d_o == 16'h0050)    phase <= 0;
      end else if (!oe_prev && flash_oe_n) begin
        reads_since <= reads_since + 1;
        rd_total    <= rd_total + 1;
      end
      we_prev <= flash_we_n;
      oe_prev <= flash_oe_n;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operation-level prediction from the command protocol
  logic [39:0] exp_q[$];
  int          exp_reads;
  logic        exp_err;

  task automatic poll_model(input logic [15:0] sr, input int br, output logic stop);
    if (br >= int'(LIMIT)) begin
      exp_reads += LIMIT;
      exp_err = 1'b1;
    end else begin
      exp_reads += br + 1;
      if ((sr & 16'h003A) != 16'h0000) exp_err = 1'b1;
    end
    stop = exp_err;
  endtask

  task automatic model_op(input logic er, input Flash_addr_t a_in, input Word_t d,
                          input int br, input logic [15:0] s1, input logic [15:0] s2);
    Flash_addr_t a, a2;
    logic stop;
    a  = {a_in[23:1], 1'b0};
    a2 = a + 24'd2;
    exp_q.delete();
    exp_reads = 0;
    exp_err   = 1'b0;
    exp_q.push_back({a, 16'h0050});
    if (er) begin
      exp_q.push_back({a, 16'h0020});
      exp_q.push_back({a, 16'h00D0});
      poll_model(s1, br, stop);
    end else begin
      exp_q.push_back({a, 16'h0040});
      exp_q.push_back({a, d[15:0]});
      poll_model(s1, br, stop);
      if (!stop) begin
        exp_q.push_back({a2, 16'h0040});
        exp_q.push_back({a2, d[31:16]});
        poll_model(s2, br, stop);
      end
    end
    exp_q.push_back({a, 16'h00FF});
  endtask

  task automatic run_op(input string name, input logic wr, input logic er,
                        input Flash_addr_t a, input Word_t d, input int br,
                        input logic [15:0] s1, input logic [15:0] s2, input logic poke);
    int wb, rb, db, cyc;
    logic got;
    busy_reads = br;
    sr1 = s1;
    sr2 = s2;
    model_op(!wr, a, d, br, s1, s2);
    wb = wr_log.size();
    rb = rd_total;
    db = done_cnt;
    @(posedge clk); #1;
    write_op = wr; erase_op = er; bus_addr = a; bus_data_write = d;
    @(posedge clk); #1;
    write_op = 1'b0; erase_op = 1'b0;
    bus_addr = Flash_addr_t'($urandom); bus_data_write = $urandom;
    cyc = 0;
    got = 1'b0;
    while (cyc < 3000 && !got) begin
      write_op = poke && (cyc == 20);
      erase_op = poke && (cyc == 20);
      @(posedge clk); #1;
      cyc++;
      if (done_cnt != db) got = 1'b1;
    end
    write_op = 1'b0; erase_op = 1'b0;
    chk({name, "_done_seen"}, 64'(got), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_done_count"}, 64'(done_cnt - db), 64'(1));
    chk({name, "_error"}, 64'(err_at_done), 64'(exp_err));
    chk({name, "_nwrites"}, 64'(wr_log.size() - wb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (wb + i < wr_log.size())
        chk($sformatf("%s_wr%0d", name, i), 64'(wr_log[wb+i]), 64'(exp_q[i]));
    chk({name, "_reads"}, 64'(rd_total - rb), 64'(exp_reads));
    chk({name, "_idle_busy"}, 64'(busy), 64'(0));
    chk({name, "_protocol"}, 64'(proto_bad), 64'(0));
    if (wr && !exp_err)
      chk({name, "_latency"}, 64'((cyc - 1) >= int'(LAT_MIN)), 64'(1));
  endtask

  logic [15:0] err_bits[4] = '{16'h0020, 16'h0010, 16'h0008, 16'h0002};

  initial begin
    int wb, db, cyc;
    logic found, wr, er;
    logic [15:0] s1, s2;
    rst = 1'b0;
    write_op = 1'b0; erase_op = 1'b0;
    bus_addr = '0; bus_data_write = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_strobes", 64'({flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe}), 64'(4'b1110));
    chk("rst_addr_data", 64'({flash_a, flash_d_o}), 64'(0));
    rst = 1'b1;

    run_op("prog", 1'b1, 1'b0, 24'h000100, 32'hDEADBEEF, 2, 16'h0080, 16'h0080, 1'b0);
    run_op("erase", 1'b0, 1'b1, 24'h020000, 32'h0, 4, 16'h0080, 16'h0080, 1'b0);
    run_op("pgm_err", 1'b1, 1'b0, 24'h000200, 32'h12345678, 1, 16'h0090, 16'h0080, 1'b0);
    run_op("timeout", 1'b1, 1'b0, 24'h000300, 32'hCAFEF00D, 1000, 16'h0080, 16'h0080, 1'b0);
    run_op("poll_edge", 1'b1, 1'b0, 24'h000401, 32'hA5A55A5A, LIMIT - 1, 16'h0080, 16'h0080, 1'b0);
    run_op("arb", 1'b1, 1'b1, 24'h000500, 32'h0040_0050, 0, 16'h0080, 16'h0080, 1'b0);
    run_op("busy_ign", 1'b1, 1'b0, 24'h000600, 32'h11112222, 3, 16'h0080, 16'h0080, 1'b1);
    run_op("wrap", 1'b1, 1'b0, 24'hFFFFFE, 32'h76543210, 0, 16'h0080, 16'h0080, 1'b0);
    chk("wrap_second_addr", 64'(wr_log[wr_log.size()-2][39:16]), 64'(0));

    // Reset while the first data halfword is being strobed
    busy_reads = 2; sr1 = 16'h0080; sr2 = 16'h0080;
    wb = wr_log.size();
    db = done_cnt;
    @(posedge clk); #1;
    write_op = 1'b1; bus_addr = 24'h000700; bus_data_write = 32'h0BADF00D;
    @(posedge clk); #1;
    write_op = 1'b0;
    found = 1'b0;
    cyc = 0;
    while (cyc < 500 && !found) begin
      @(posedge clk); #1;
      cyc++;
      if (wr_log.size() - wb == 2 && !flash_we_n) found = 1'b1;
    end
    chk("rst_mid_reached", 64'(found), 64'(1));
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe, busy, done}),
        64'(6'b111000));
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt - db), 64'(0));
    chk("rst_mid_no_restore", 64'(wr_log.size() - wb), 64'(2));
    run_op("after_rst", 1'b1, 1'b0, 24'h000700, 32'h0BADF00D, 1, 16'h0080, 16'h0080, 1'b0);

    for (int n = 0; n < 8; n++) begin
      wr = 1'(($urandom_range(0, 2)) != 0);
      er = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      s1 = 16'h0080 | (16'($urandom) & 16'h0045);
      s2 = 16'h0080 | (16'($urandom) & 16'h0045);
      if ($urandom_range(0, 3) == 0) s1 = s1 | err_bits[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) s2 = s2 | err_bits[$urandom_range(0, 3)];
      run_op($sformatf("rnd%0d", n), wr, er, Flash_addr_t'($urandom), $urandom,
             int'($urandom_range(0, 5)), s1, s2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
